// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, through two
// cascaded half adders, wrapped in a start/busy/done handshake.

module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             hs0;
    logic             hc0;
    logic             s;
    logic             hc1;
    logic             c;
    logic             last;
    logic [WIDTH-1:0] res_next;

    halfadder u_ha0 (
        .a (a_sh[0]),
        .b (b_sh[0]),
        .s (hs0),
        .c (hc0)
    );

    halfadder u_ha1 (
        .a (hs0),
        .b (carry),
        .s (s),
        .c (hc1)
    );

    assign c    = hc0 | hc1;
    assign last = (cnt == CW'(WIDTH - 1));

    // res_sh keeps only the WIDTH-1 bits already produced; the new bit completes the word
    assign res_next = {s, res_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    res_sh <= res_next[WIDTH-1:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= c;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        sum  <= res_next;
                        cout <= c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder (WIDTH=8): latency, results,
// ignored start, mid-operation reset and result hold.

module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total = 0;
    int bad   = 0;
    int doubleDone = 0;
    logic prevDone = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done && prevDone) doubleDone <= doubleDone + 1;
        prevDone <= done;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the first negedge after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        a = av;
        b = bv;
        cin = cv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busyCnt);
        lat = 1;
        busyCnt = 0;
        while (!done && lat < 30) begin
            if (busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runAdd(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic checkTiming);
        int lat;
        int busyCnt;
        logic [WIDTH:0] expv;
        expv = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
        applyStimulus(av, bv, cv);
        waitDone(lat, busyCnt);
        if (checkTiming) begin
            checkOutput({tag, "_latency"}, lat, 9);
            checkOutput({tag, "_busycycles"}, busyCnt, 8);
        end
        checkOutput({tag, "_done"}, {31'd0, done}, 1);
        checkOutput({tag, "_result"}, {23'd0, cout, sum}, {23'd0, expv});
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int busyCnt;
        int doneCnt;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rc;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 0);
        checkOutput("reset_done", {31'd0, done}, 0);
        checkOutput("reset_sum", {24'd0, sum}, 0);
        checkOutput("reset_cout", {31'd0, cout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        runAdd("basic", 8'h0F, 8'h01, 1'b0, 1'b1);
        checkOutput("basic_sum", {24'd0, sum}, 32'h10);
        runAdd("wrap1", 8'hFF, 8'h01, 1'b0, 1'b1);
        checkOutput("wrap1_sum", {23'd0, cout, sum}, 32'h100);
        runAdd("wrap2", 8'hFF, 8'hFF, 1'b1, 1'b1);
        checkOutput("wrap2_sum", {23'd0, cout, sum}, 32'h1FF);

        // start held high through ADD and into DONE, operand changed mid-op
        a = 8'h11;
        b = 8'h22;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!done && lat < 30) begin
            if (lat == 3) a = 8'hAA;
            @(negedge clk);
            lat++;
        end
        checkOutput("ignore_latency", lat, 9);
        checkOutput("ignore_result", {23'd0, cout, sum}, 32'h033);
        @(negedge clk);
        checkOutput("ignore_busy_after_done", {31'd0, busy}, 0);
        start = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("ignore_extra_done", doneCnt, 0);
        checkOutput("ignore_sum_held", {24'd0, sum}, 32'h33);

        // reset in the middle of an operation
        applyStimulus(8'h80, 8'h80, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", {31'd0, busy}, 0);
        checkOutput("midreset_sum", {24'd0, sum}, 0);
        checkOutput("midreset_cout", {31'd0, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("midreset_no_done", doneCnt, 0);
        checkOutput("midreset_sum_after", {23'd0, cout, sum}, 0);

        // result hold and start in the first IDLE cycle
        runAdd("hold", 8'h3C, 8'h03, 1'b0, 1'b1);
        checkOutput("hold_sum_idle", {24'd0, sum}, 32'h3F);
        applyStimulus(8'h01, 8'h01, 1'b0);
        checkOutput("hold_sum_during_add", {24'd0, sum}, 32'h3F);
        waitDone(lat, busyCnt);
        checkOutput("b2b_latency", lat, 9);
        checkOutput("b2b_result", {23'd0, cout, sum}, 32'h002);
        @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            runAdd("random", ra, rb, rc, 1'b0);
        end

        @(negedge clk);
        checkOutput("no_double_done", doubleDone, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
